// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant lock and hold-time preemption.
// One-hot registered grant; every handover passes through one idle cycle.
module rr_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic            preempt_s;

    // First set request bit scanning upward from last+1, wrapping; MSB is the found flag.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] last);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] kk;
        int            k;
        found = 1'b0;
        idx   = {IW{1'b0}};
        for (int i = 1; i <= N; i++) begin
            k = int'(last) + i;
            if (k >= N) begin
                k = k - N;
            end else begin
                k = k;
            end
            kk = IW'(k);
            if (!found && req[kk]) begin
                found = 1'b1;
                idx   = kk;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign {found_s, pick_s} = rr_pick(request, last_q);
    assign preempt_s = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) && (|(request & ~grant_q));

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = GRANT;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick_s;
                    valid_d = 1'b1;
                    id_d    = pick_s;
                    hold_d  = HW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Release and preemption both go through an all-zero dead cycle.
                if (!request[id_q] || preempt_s) begin
                    state_d = IDLE;
                    grant_d = {N{1'b0}};
                    valid_d = 1'b0;
                    id_d    = {IW{1'b0}};
                    last_d  = id_q;
                    hold_d  = {HW{1'b0}};
                end else if ((MAX_HOLD != 0) && (hold_q < HW'(MAX_HOLD))) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {N{1'b0}};
                valid_d = 1'b0;
                id_d    = {IW{1'b0}};
                hold_d  = {HW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= {N{1'b0}};
            valid_q <= 1'b0;
            id_q    <= {IW{1'b0}};
            last_q  <= IW'(N - 1);
            hold_q  <= {HW{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: instance a uses MAX_HOLD=4, instance b MAX_HOLD=0.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] request;
    logic [1:0] ga, gb;
    logic       va, vb;
    logic       ida, idb;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] ea;
        logic       cb;
        logic [1:0] eb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    rr_arbiter #(.N(2), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .request(request),
        .grant(ga), .grant_valid(va), .grant_id(ida)
    );

    rr_arbiter #(.N(2), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .request(request),
        .grant(gb), .grant_valid(vb), .grant_id(idb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {valid,id,grant}=%b required %b", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per clock and compares both instances.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("grant_a", {va, ida, ga}, {|mon_e.ea, mon_e.ea[1], mon_e.ea});
            if (mon_e.cb) begin
                check("grant_b", {vb, idb, gb}, {|mon_e.eb, mon_e.eb[1], mon_e.eb});
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] req, input logic [1:0] ea,
                        input logic cb, input logic [1:0] eb);
        exp_t t;
        @(negedge clk);
        rst     = r;
        request = req;
        t.ea = ea;
        t.cb = cb;
        t.eb = eb;
        sb_q.push_back(t);
    endtask

    logic [1:0] pat;

    initial begin
        rst     = 1'b1;
        request = 2'b00;

        // Reset, then a single requester keeps its grant.
        step(1'b1, 2'b00, 2'b00, 1'b1, 2'b00);
        step(1'b1, 2'b00, 2'b00, 1'b1, 2'b00);
        step(1'b0, 2'b01, 2'b01, 1'b1, 2'b01);
        step(1'b0, 2'b01, 2'b01, 1'b1, 2'b01);

        // Priority after reset and handover on release.
        step(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b11, 2'b01, 1'b0, 2'b00);
        step(1'b0, 2'b10, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b10, 2'b10, 1'b0, 2'b00);

        // Fairness under continuous contention.
        step(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        for (int i = 0; i < 14; i++) begin
            case (i % 10)
                0, 1, 2, 3: pat = 2'b01;
                5, 6, 7, 8: pat = 2'b10;
                default:    pat = 2'b00;
            endcase
            step(1'b0, 2'b11, pat, 1'b0, 2'b00);
        end

        // Lone holder is never preempted.
        step(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
        end

        // Mid-grant reset, then requester 0 wins.
        step(1'b1, 2'b11, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b11, 2'b01, 1'b0, 2'b00);

        // One-cycle request pulse.
        step(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
        step(1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

        // No preemption when MAX_HOLD=0 (instance b), while a keeps rotating.
        step(1'b1, 2'b00, 2'b00, 1'b1, 2'b00);
        for (int i = 0; i < 30; i++) begin
            case (i % 10)
                0, 1, 2, 3: pat = 2'b01;
                5, 6, 7, 8: pat = 2'b10;
                default:    pat = 2'b00;
            endcase
            step(1'b0, 2'b11, pat, 1'b1, 2'b01);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
